// File: rtl/mem2_stage.sv
// mem2_stage: second memory pipeline stage of the integer pipe.
// Registers MEM results and waits for the Dcache read-data pulse. The pulse
// is held in a buffer so the load result survives pipeline freezes. Load data
// is aligned and extended here; the final writeback value and destination go
// to WB and the bypass network.
module mem2_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        MEM2_Flush,
    input  logic        MEM2_Wr,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_Result,
    input  logic [31:0] MEM_ALUOut,
    input  logic [4:0]  MEM_Dst,
    input  logic        MEM_RegWr,
    input  logic        MEM_ReadMem,
    input  logic        MEM_LoadSign,
    input  logic [1:0]  MEM_LoadSize,
    input  logic        MEM_ExcValid,
    input  logic        dcache_rvalid,
    input  logic [31:0] dcache_rdata,
    output logic        MEM2_StallReq,
    output logic [31:0] MEM2_PC,
    output logic [4:0]  MEM2_Dst,
    output logic        MEM2_RegWr,
    output logic [31:0] MEM2_WbData,
    output logic        MEM2_WbValid
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HELD = 2'b10
    } state_t;

    // Stage register payload; only the low address bits matter for alignment.
    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] result;
        logic [1:0]    off;
        logic [RW-1:0] dst;
        logic          regwr;
        logic          readmem;
        logic          sign;
        logic [1:0]    size;
    } stage_t;

    state_t        state_q;
    state_t        state_d;
    stage_t        stg_q;
    stage_t        stg_in;
    logic [DW-1:0] buf_q;

    logic          stall_c;
    logic          ld_en_c;
    logic          new_load_c;
    logic          buf_cap_c;
    logic [DW-1:0] raw_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [DW-1:0] load_data_c;

    // Upper address bits are not needed past MEM; fold them away explicitly.
    logic unused_c;
    assign unused_c = ^MEM_ALUOut[31:2];

    // Freeze request while a load is outstanding; same-cycle rvalid releases it.
    assign stall_c = (state_q == ST_WAIT) && !dcache_rvalid;

    // A stalled stage never loads, even if the hazard unit asserts MEM2_Wr.
    assign ld_en_c    = MEM2_Wr && !stall_c;
    assign new_load_c = MEM_ReadMem && !MEM_ExcValid;

    // Incoming stage payload with exception masking applied.
    always_comb begin
        stg_in         = '0;
        stg_in.pc      = MEM_PC;
        stg_in.result  = MEM_Result;
        stg_in.off     = MEM_ALUOut[1:0];
        stg_in.dst     = MEM_Dst;
        stg_in.regwr   = MEM_RegWr && !MEM_ExcValid;
        stg_in.readmem = new_load_c;
        stg_in.sign    = MEM_LoadSign;
        stg_in.size    = MEM_LoadSize;
    end

    // Stage register: flush clears, load enable captures, otherwise hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_q <= '0;
        end else if (MEM2_Flush) begin
            stg_q <= '0;
        end else if (ld_en_c) begin
            stg_q <= stg_in;
        end
    end

    // Load FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load FSM next state and hold-buffer capture decision.
    always_comb begin
        state_d   = state_q;
        buf_cap_c = 1'b0;
        if (MEM2_Flush) begin
            state_d = ST_IDLE;
        end else if (ld_en_c) begin
            if (new_load_c) begin
                state_d   = dcache_rvalid ? ST_HELD : ST_WAIT;
                buf_cap_c = dcache_rvalid;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_WAIT) && dcache_rvalid) begin
            state_d   = ST_HELD;
            buf_cap_c = 1'b1;
        end
    end

    // Hold buffer: keeps returned load data across pipeline freezes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q <= '0;
        end else if (MEM2_Flush) begin
            buf_q <= '0;
        end else if (buf_cap_c) begin
            buf_q <= dcache_rdata;
        end
    end

    // Lane extraction and extension of load data.
    always_comb begin
        raw_c  = (state_q == ST_HELD) ? buf_q : dcache_rdata;
        byte_c = 8'(raw_c >> (8 * 32'(stg_q.off)));
        half_c = stg_q.off[1] ? raw_c[31:16] : raw_c[15:0];
        case (stg_q.size)
            SZ_BYTE: load_data_c = {{24{stg_q.sign & byte_c[7]}}, byte_c};
            SZ_HALF: load_data_c = {{16{stg_q.sign & half_c[15]}}, half_c};
            default: load_data_c = raw_c;
        endcase
    end

    // Stage outputs toward WB, bypass network and hazard unit.
    always_comb begin
        MEM2_StallReq = stall_c;
        MEM2_PC       = stg_q.pc;
        MEM2_Dst      = stg_q.dst;
        MEM2_RegWr    = stg_q.regwr;
        MEM2_WbData   = stg_q.readmem ? load_data_c : stg_q.result;
        MEM2_WbValid  = !stg_q.readmem
                     || (state_q == ST_HELD)
                     || ((state_q == ST_WAIT) && dcache_rvalid);
    end

endmodule

// File: tb/tb_mem2_stage.sv
// Scoreboard bench for mem2_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever a new result is presented.
module tb_mem2_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        MEM2_Flush = 1'b0;
    logic        MEM2_Wr = 1'b0;
    logic [31:0] MEM_PC = '0;
    logic [31:0] MEM_Result = '0;
    logic [31:0] MEM_ALUOut = '0;
    logic [4:0]  MEM_Dst = '0;
    logic        MEM_RegWr = 1'b0;
    logic        MEM_ReadMem = 1'b0;
    logic        MEM_LoadSign = 1'b0;
    logic [1:0]  MEM_LoadSize = '0;
    logic        MEM_ExcValid = 1'b0;
    logic        dcache_rvalid = 1'b0;
    logic [31:0] dcache_rdata = '0;
    logic        MEM2_StallReq;
    logic [31:0] MEM2_PC;
    logic [4:0]  MEM2_Dst;
    logic        MEM2_RegWr;
    logic [31:0] MEM2_WbData;
    logic        MEM2_WbValid;

    mem2_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .MEM2_Flush    (MEM2_Flush),
        .MEM2_Wr       (MEM2_Wr),
        .MEM_PC        (MEM_PC),
        .MEM_Result    (MEM_Result),
        .MEM_ALUOut    (MEM_ALUOut),
        .MEM_Dst       (MEM_Dst),
        .MEM_RegWr     (MEM_RegWr),
        .MEM_ReadMem   (MEM_ReadMem),
        .MEM_LoadSign  (MEM_LoadSign),
        .MEM_LoadSize  (MEM_LoadSize),
        .MEM_ExcValid  (MEM_ExcValid),
        .dcache_rvalid (dcache_rvalid),
        .dcache_rdata  (dcache_rdata),
        .MEM2_StallReq (MEM2_StallReq),
        .MEM2_PC       (MEM2_PC),
        .MEM2_Dst      (MEM2_Dst),
        .MEM2_RegWr    (MEM2_RegWr),
        .MEM2_WbData   (MEM2_WbData),
        .MEM2_WbValid  (MEM2_WbValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  dst;
        logic        regwr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic        last_valid = 1'b1;
    logic [31:0] last_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] pc, input logic [31:0] data,
                        input logic [4:0] dst, input logic regwr);
        exp_t e;
        e.name = name; e.pc = pc; e.data = data; e.dst = dst; e.regwr = regwr;
        sb.push_back(e);
    endtask

    // Drive one MEM instruction for a single register-load edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] alu,
                         input logic [4:0] dst, input logic regwr, input logic rd,
                         input logic sgn, input logic [1:0] sz, input logic exc,
                         input logic rv, input logic [31:0] rdata);
        MEM_PC = pc; MEM_Result = res; MEM_ALUOut = alu; MEM_Dst = dst;
        MEM_RegWr = regwr; MEM_ReadMem = rd; MEM_LoadSign = sgn; MEM_LoadSize = sz;
        MEM_ExcValid = exc; dcache_rvalid = rv; dcache_rdata = rdata;
        MEM2_Wr = 1'b1;
        @(posedge clk); #1;
        MEM2_Wr = 1'b0; dcache_rvalid = 1'b0; MEM_ReadMem = 1'b0; MEM_ExcValid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},    MEM2_PC, 32'h0);
        chk({tag, "_dst"},   32'(MEM2_Dst), 32'h0);
        chk({tag, "_regwr"}, 32'(MEM2_RegWr), 32'h0);
        chk({tag, "_data"},  MEM2_WbData, 32'h0);
        chk({tag, "_valid"}, 32'(MEM2_WbValid), 32'h1);
        chk({tag, "_stall"}, 32'(MEM2_StallReq), 32'h0);
    endtask

    // Monitor: a result is presented when WbValid rises or the PC changes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (MEM2_WbValid && (!last_valid || MEM2_PC != last_pc)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc 0x%08h data 0x%08h, none expected",
                             MEM2_PC, MEM2_WbData);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_pc"},    MEM2_PC, e.pc);
                    chk({e.name, "_data"},  MEM2_WbData, e.data);
                    chk({e.name, "_dst"},   32'(MEM2_Dst), 32'(e.dst));
                    chk({e.name, "_regwr"}, 32'(MEM2_RegWr), 32'(e.regwr));
                end
            end
            last_valid = MEM2_WbValid;
            last_pc    = MEM2_PC;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 resetn = 1'b0;
        #5 chk_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        // ALU result passes through in one cycle
        push("alu", 32'h100, 32'h12345678, 5'd5, 1'b1);
        issue(32'h100, 32'h12345678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
        @(negedge clk) chk("alu_stall", 32'(MEM2_StallReq), 32'h0);

        // LB signed, lane 3, data one cycle after the load enters
        push("lb", 32'h104, 32'hFFFFFF80, 5'd6, 1'b1);
        issue(32'h104, 32'h0, 32'h1003, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lb_stall_wait", 32'(MEM2_StallReq), 32'h1);
        chk("lb_valid_wait", 32'(MEM2_WbValid), 32'h0);
        @(posedge clk); #1;
        dcache_rvalid = 1'b1; dcache_rdata = 32'h80FF0000;
        @(negedge clk) chk("lb_stall_release", 32'(MEM2_StallReq), 32'h0);
        @(posedge clk); #1;
        dcache_rvalid = 1'b0; dcache_rdata = 32'h0;
        @(negedge clk) chk("lb_held_data", MEM2_WbData, 32'hFFFFFF80);

        // LHU upper half, held across three frozen cycles
        push("lhu", 32'h108, 32'h0000BEEF, 5'd7, 1'b1);
        issue(32'h108, 32'h0, 32'h2002, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
        @(negedge clk) chk("lhu_stall_wait", 32'(MEM2_StallReq), 32'h1);
        @(posedge clk); #1;
        dcache_rvalid = 1'b1; dcache_rdata = 32'hBEEF1234;
        @(posedge clk); #1;
        dcache_rvalid = 1'b0; dcache_rdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lhu_hold%0d_data", i), MEM2_WbData, 32'h0000BEEF);
            chk($sformatf("lhu_hold%0d_stall", i), 32'(MEM2_StallReq), 32'h0);
        end
        @(posedge clk); #1;

        // LW with rvalid on the same edge as the register load
        push("lw", 32'h10C, 32'hCAFEBABE, 5'd8, 1'b1);
        issue(32'h10C, 32'h0, 32'h3000, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hCAFEBABE);
        @(negedge clk) chk("lw_stall", 32'(MEM2_StallReq), 32'h0);

        // LBU lane 1 and LH signed lane 0, both same-edge
        push("lbu", 32'h120, 32'h0000008F, 5'd9, 1'b1);
        issue(32'h120, 32'h0, 32'h4001, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h12348F56);
        push("lh", 32'h124, 32'hFFFF8001, 5'd10, 1'b1);
        issue(32'h124, 32'h0, 32'h4000, 5'd10, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h7FFF8001);
        @(negedge clk);

        // Flush while waiting; the late pulse must be discarded
        issue(32'h110, 32'h0, 32'h5000, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
        MEM2_Flush = 1'b1;
        push("flush", 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk) chk("flush_stall_wait", 32'(MEM2_StallReq), 32'h1);
        @(posedge clk); #1;
        MEM2_Flush = 1'b0; dcache_rvalid = 1'b1; dcache_rdata = 32'hDEADBEEF;
        @(negedge clk) chk("flush_stall", 32'(MEM2_StallReq), 32'h0);
        @(posedge clk); #1;
        dcache_rvalid = 1'b0;
        @(negedge clk) chk("flush_discard", MEM2_WbData, 32'h0);

        // Load with exception: no write, no stall, result passes through
        push("exc", 32'h114, 32'h00000055, 5'd12, 1'b0);
        issue(32'h114, 32'h55, 32'h6000, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0);
        @(negedge clk) chk("exc_stall", 32'(MEM2_StallReq), 32'h0);

        // Asynchronous reset while waiting for load data
        issue(32'h118, 32'h0, 32'h7000, 5'd13, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
        @(negedge clk) chk("rst_stall_wait", 32'(MEM2_StallReq), 32'h1);
        push("rst", 32'h0, 32'h0, 5'd0, 1'b0);
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("rst_async");
        @(posedge clk); #1;
        resetn = 1'b1; dcache_rvalid = 1'b1; dcache_rdata = 32'h11223344;
        @(negedge clk);
        chk("rst_late_stall", 32'(MEM2_StallReq), 32'h0);
        chk("rst_late_data", MEM2_WbData, 32'h0);
        chk("rst_late_valid", 32'(MEM2_WbValid), 32'h1);
        @(posedge clk); #1;
        dcache_rvalid = 1'b0;

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
